// File: rtl/pixel_group_tot_toa_if.sv
// Readout port of the pixel group: one valid/ready word per drained pixel.
interface pixel_group_tot_toa_if #(
    parameter int N_PIX  = 4,
    parameter int AW     = $clog2(N_PIX),
    parameter int TS_W   = 9,
    parameter int TOT_W  = 8,
    parameter int FTOA_W = 5
);
    logic              rd_valid;
    logic              rd_ready;
    logic [AW-1:0]     rd_addr;
    logic [TS_W-1:0]   rd_timestamp;
    logic [TOT_W-1:0]  rd_tot;
    logic [FTOA_W-1:0] rd_ftoa;

    modport master (output rd_valid, rd_addr, rd_timestamp, rd_tot, rd_ftoa,
                    input  rd_ready);
    modport slave  (input  rd_valid, rd_addr, rd_timestamp, rd_tot, rd_ftoa,
                    output rd_ready);
endinterface

// File: rtl/pixel_group_tot_toa.sv
// N-pixel ToA/ToT (or windowed hit-count) front-end with a round-robin
// arbiter draining finished pixels through a registered valid/ready port.

module pixel_group_tot_toa_pix #(
    parameter int TS_W   = 9,
    parameter int TOT_W  = 8,
    parameter int FTOA_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_hit,
    input  logic              i_shutter,
    input  logic              i_shut_fall,
    input  logic              i_mode,
    input  logic              i_clr,
    input  logic              i_grant,
    input  logic [TS_W-1:0]   i_ts,
    input  logic [FTOA_W-1:0] i_ftoa,
    output logic              o_meas,
    output logic              o_done,
    output logic [TS_W-1:0]   o_ts,
    output logic [TOT_W-1:0]  o_tot,
    output logic [FTOA_W-1:0] o_ftoa
);
    typedef enum logic [1:0] {S_IDLE, S_MEAS, S_DONE} state_t;

    state_t            r_state, w_nxt_state;
    logic              r_hit_d;
    logic [TS_W-1:0]   r_ts, w_nxt_ts;
    logic [TOT_W-1:0]  r_tot, w_nxt_tot, w_inc;
    logic [FTOA_W-1:0] r_ftoa, w_nxt_ftoa;
    logic              w_rise;

    assign w_rise = i_hit & ~r_hit_d;
    assign w_inc  = (&r_tot) ? r_tot : r_tot + TOT_W'(1);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ts    = r_ts;
        w_nxt_tot   = r_tot;
        w_nxt_ftoa  = r_ftoa;
        if (i_clr) begin
            w_nxt_state = S_IDLE;
            w_nxt_ts    = '0;
            w_nxt_tot   = '0;
            w_nxt_ftoa  = '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_rise && i_shutter) begin
                    w_nxt_state = S_MEAS;
                    w_nxt_ts    = i_ts;
                    w_nxt_ftoa  = i_mode ? '0 : i_ftoa;
                    w_nxt_tot   = TOT_W'(1);
                end
                S_MEAS: begin
                    // shutter close truncates the measurement in both modes
                    if (i_shut_fall)   w_nxt_state = S_DONE;
                    else if (!i_mode) begin
                        if (i_hit)     w_nxt_tot   = w_inc;
                        else           w_nxt_state = S_DONE;
                    end else if (w_rise) w_nxt_tot = w_inc;
                end
                S_DONE: if (i_grant) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_tot   = '0;
                end
                default: w_nxt_state = S_IDLE;
            endcase
        end
    end

    // hit_d keeps tracking through a clear so a held hit cannot retrigger
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_hit_d <= 1'b0;
            r_ts    <= '0;
            r_tot   <= '0;
            r_ftoa  <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_hit_d <= i_hit;
            r_ts    <= w_nxt_ts;
            r_tot   <= w_nxt_tot;
            r_ftoa  <= w_nxt_ftoa;
        end
    end

    assign o_meas = (r_state == S_MEAS);
    assign o_done = (r_state == S_DONE);
    assign o_ts   = r_ts;
    assign o_tot  = r_tot;
    assign o_ftoa = r_ftoa;
endmodule

module pixel_group_tot_toa #(
    parameter int N_PIX  = 4,
    parameter int AW     = $clog2(N_PIX),
    parameter int TS_W   = 9,
    parameter int TOT_W  = 8,
    parameter int FTOA_W = 5
) (
    input  logic                    clk_40MHz,
    input  logic                    rst_n,
    input  logic                    shutter,
    input  logic                    out_flag,
    input  logic                    mode,
    input  logic [TS_W-1:0]         TimeStamp,
    input  logic [N_PIX-1:0]        hit_pixel,
    input  logic [N_PIX*FTOA_W-1:0] ftoa_in,
    output logic                    hit_or,
    output logic [N_PIX-1:0]        hit_over,
    pixel_group_tot_toa_if.master   rd
);
    logic              r_shutter_d, r_mode_q;
    logic [AW-1:0]     r_last;
    logic              r_valid;
    logic [AW-1:0]     r_addr;
    logic [TS_W-1:0]   r_ts;
    logic [TOT_W-1:0]  r_tot;
    logic [FTOA_W-1:0] r_ftoa;

    logic                          w_shut_rise, w_shut_fall, w_mode;
    logic [N_PIX-1:0]              w_meas, w_done, w_grant;
    logic [N_PIX-1:0][TS_W-1:0]    w_ts;
    logic [N_PIX-1:0][TOT_W-1:0]   w_tot;
    logic [N_PIX-1:0][FTOA_W-1:0]  w_ftoa;
    logic                          w_load, w_any;
    logic [AW-1:0]                 w_sel, w_idx;

    assign w_shut_rise = shutter & ~r_shutter_d;
    assign w_shut_fall = ~shutter & r_shutter_d;
    // a hit arriving with the shutter edge already uses the newly sampled mode
    assign w_mode      = w_shut_rise ? mode : r_mode_q;

    for (genvar gi = 0; gi < N_PIX; gi++) begin : g_pix
        pixel_group_tot_toa_pix #(.TS_W(TS_W), .TOT_W(TOT_W), .FTOA_W(FTOA_W)) u_pix (
            .clk        (clk_40MHz),
            .rst_n      (rst_n),
            .i_hit      (hit_pixel[gi]),
            .i_shutter  (shutter),
            .i_shut_fall(w_shut_fall),
            .i_mode     (w_mode),
            .i_clr      (out_flag),
            .i_grant    (w_grant[gi]),
            .i_ts       (TimeStamp),
            .i_ftoa     (ftoa_in[gi*FTOA_W +: FTOA_W]),
            .o_meas     (w_meas[gi]),
            .o_done     (w_done[gi]),
            .o_ts       (w_ts[gi]),
            .o_tot      (w_tot[gi]),
            .o_ftoa     (w_ftoa[gi])
        );
    end

    assign w_load = ~r_valid | rd.rd_ready;

    // scan from the farthest offset down so the nearest DONE pixel wins
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_idx = '0;
        for (int off = N_PIX; off >= 1; off--) begin
            if (int'(r_last) + off >= N_PIX) w_idx = r_last + AW'(off) - AW'(N_PIX);
            else                             w_idx = r_last + AW'(off);
            if (w_done[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_load && w_any && !out_flag) w_grant[w_sel] = 1'b1;
    end

    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_shutter_d <= 1'b0;
            r_mode_q    <= 1'b0;
            r_last      <= AW'(N_PIX - 1);
            r_valid     <= 1'b0;
            r_addr      <= '0;
            r_ts        <= '0;
            r_tot       <= '0;
            r_ftoa      <= '0;
        end else begin
            r_shutter_d <= shutter;
            if (w_shut_rise) r_mode_q <= mode;
            if (out_flag) begin
                r_valid <= 1'b0;
                r_last  <= AW'(N_PIX - 1);
            end else if (w_load) begin
                if (w_any) begin
                    r_valid <= 1'b1;
                    r_addr  <= w_sel;
                    r_ts    <= w_ts[w_sel];
                    r_tot   <= w_tot[w_sel];
                    r_ftoa  <= w_ftoa[w_sel];
                    r_last  <= w_sel;
                end else begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign hit_or          = |w_meas;
    assign hit_over        = w_done;
    assign rd.rd_valid     = r_valid;
    assign rd.rd_addr      = r_addr;
    assign rd.rd_timestamp = r_ts;
    assign rd.rd_tot       = r_tot;
    assign rd.rd_ftoa      = r_ftoa;
endmodule

// File: doc/pixel_group_tot_toa.md
# pixel_group_tot_toa

Parametrised N-pixel front-end group that generalises the single-pixel ToT/ToA cell. Each pixel runs its own measurement FSM in one of two modes: ToA+ToT or shutter-windowed hit counting. A round-robin arbiter drains finished pixels one at a time through a valid/ready readout port. It sits between the pixel discriminators/fine-TDCs and the column readout logic.

## Interface
- N_PIX, 4, number of pixels (≥2)
- AW, $clog2(N_PIX), pixel address width
- TS_W, 9, coarse timestamp width
- TOT_W, 8, ToT / hit-count width
- FTOA_W, 5, fine-ToA width
- clk_40MHz  in  1  single clock for the whole block
- rst_n  in  1  asynchronous, active-low reset
- shutter  in  1  acquisition window; pixels arm only while high
- out_flag  in  1  synchronous global clear, 1-cycle pulse
- mode  in  1  0 = ToA+ToT, 1 = hit count; sampled at the shutter rising edge
- TimeStamp  in  TS_W  free-running coarse time
- hit_pixel  in  N_PIX  discriminator outputs, already synchronous to clk_40MHz
- ftoa_in  in  N_PIX*FTOA_W  per-pixel fine ToA, valid in the hit rising-edge cycle
- hit_or  out  1  OR of all pixels in MEAS
- hit_over  out  N_PIX  per-pixel DONE flag
- rd_valid  out  1  readout word valid
- rd_ready  in  1  consumer accepts the word
- rd_addr  out  AW  pixel index
- rd_timestamp  out  TS_W  latched ToA
- rd_tot  out  TOT_W  ToT (mode 0) or hit count (mode 1)
- rd_ftoa  out  FTOA_W  latched fine ToA; 0 in mode 1

## Operation
- Per-pixel registers: hit_d, state {IDLE, MEAS, DONE}, ts, tot, ftoa.
- Rising edge = hit_pixel[i] & ~hit_d[i].
- mode_q is loaded from mode on a shutter rising edge. A mode change while shutter=1 is ignored.
- Mode 0:
  - IDLE→MEAS on a rising edge with shutter=1. Latch ts=TimeStamp, ftoa=ftoa_in slice, tot=1.
  - MEAS, hit high: tot increments, saturating at 2^TOT_W−1.
  - MEAS→DONE on the first cycle hit is sampled low.
  - MEAS→DONE also on a shutter falling edge, keeping the truncated tot.
- Mode 1:
  - While shutter=1, every rising edge increments tot, saturating.
  - The first rising edge also latches ts and moves the pixel IDLE→MEAS.
  - On a shutter falling edge, every MEAS pixel →DONE. Pixels with a zero count stay IDLE.
- DONE pixels ignore hits until they are read out.
- A pixel that is still high when it returns to IDLE does not retrigger; a new rising edge is required.
- Arbiter and output register:
  - The output register loads when rd_valid=0, or when rd_valid&rd_ready.
  - It loads from the first DONE pixel in round-robin order, starting at last_grant+1 mod N_PIX.
  - The granted pixel goes DONE→IDLE in the same cycle and clears its tot.
  - If no pixel is DONE at an accept, rd_valid drops.
  - Output fields hold stable while rd_valid=1 and rd_ready=0.
- out_flag has priority over everything:
  - All pixels →IDLE and all counters clear.
  - rd_valid→0 and last_grant→N_PIX−1.
  - Hits in the out_flag cycle are ignored.
- Reset values: all outputs 0 (hit_or, hit_over, rd_valid, rd_addr, rd_timestamp, rd_tot, rd_ftoa). All states IDLE, hit_d=0, mode_q=0, last_grant=N_PIX−1.

## Timing
- Rising edge sampled at clock edge k: MEAS and hit_or visible after edge k.
- Falling edge sampled at edge e: DONE and hit_over visible after e; rd_valid visible after e+1.
- Mode-0 ToT equals the number of clock edges at which hit was sampled high.
- Readout throughput: one word per cycle while rd_ready=1 and pixels are DONE.
- A pixel finishing in the same cycle as an accept is eligible in the next cycle.
- TimeStamp wraps mod 2^TS_W. Latched ts is raw and no unwrap is applied.
- Simultaneous shutter fall and hit rise: the rise is ignored, since arming requires shutter=1 in that cycle.

## Test plan
- Mode 0, pixel 2:
  - Stimulus: hit high for 3 cycles starting when TimeStamp=5, ftoa=0x13, rd_ready=1.
  - Response: rd_addr=2, rd_timestamp=5, rd_tot=3, rd_ftoa=0x13; rd_valid for 1 cycle, 2 cycles after the fall.
- Saturation:
  - Stimulus: hit held 300 cycles, TOT_W=8.
  - Response: rd_tot=255.
- Round-robin:
  - Stimulus: pixels 0, 1, 3 finish in the same cycle with rd_ready=1; then pixel 0 again.
  - Response: addresses 0, 1, 3; then 0 on its next completion.
- Backpressure:
  - Stimulus: rd_ready=0 for 10 cycles with 2 pixels DONE.
  - Response: word stable and hit_over bits held; after ready, 2 words on consecutive cycles.
- Mode 1:
  - Stimulus: shutter open, pixel 1 pulses 4 times, pixel 0 none, then shutter falls.
  - Response: single word, addr=1, tot=4, ftoa=0, ts=TimeStamp at the first pulse.
- Clears:
  - Stimulus: out_flag while pixel 3 is in MEAS and rd_valid=1.
  - Response: next cycle rd_valid=0, hit_or=0, hit_over=0, and the ongoing hit is not retriggered.
  - Stimulus: rst_n low mid-measurement.
  - Response: all outputs 0 immediately.
